// File: rtl/c2v_symconv_rr_sched.sv
// Round-robin shared C2V sign-conversion unit with per-layer accept counting and a layer-done pulse.
// Latency: accept to out_valid_o is 1 cycle. Backpressure: a stalled output slot withholds every req_ready_o.
// Build option C2V_SYMCONV_ZERO_SIGN_CLR_EN forces the output sign to 0 when the magnitude is zero.
module c2v_symconv_rr_sched #(
    parameter int MSG_WIDTH    = 4,
    parameter int REQ_NUM      = 4,
    parameter int REQ_ID_WIDTH = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         layer_start_i,
    input  logic [CNT_WIDTH-1:0]         layer_msg_cnt_i,
    input  logic [REQ_NUM-1:0]           req_valid_i,
    output logic [REQ_NUM-1:0]           req_ready_o,
    input  logic [REQ_NUM-1:0]           req_v2c_sign_i,
    input  logic [REQ_NUM*MSG_WIDTH-1:0] req_c2v_msg_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [MSG_WIDTH-1:0]         out_msg_o,
    output logic [REQ_ID_WIDTH-1:0]      out_req_id_o,
    output logic                         busy_o,
    output logic                         layer_done_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [REQ_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [CNT_WIDTH-1:0]    target_q, target_d;
    logic [CNT_WIDTH-1:0]    count_inc;
    logic                    out_vld_q, out_vld_d;
    logic [MSG_WIDTH-1:0]    out_msg_q, out_msg_d;
    logic [REQ_ID_WIDTH-1:0] out_id_q, out_id_d;

    logic                    slot_free;
    logic                    gnt_vld;
    logic [REQ_ID_WIDTH-1:0] gnt_id;
    logic [MSG_WIDTH-1:0]    sel_msg;
    logic                    conv_sign;
    int unsigned             idx;

    assign slot_free = ~out_vld_q | out_ready_i;
    assign count_inc = count_q + 1'b1;

    // Search starts at rr_ptr and wraps, so the last winner gets lowest priority next time.
    always_comb begin
        gnt_vld     = 1'b0;
        gnt_id      = '0;
        idx         = 0;
        req_ready_o = '0;
        if (state_q == ST_RUN && slot_free) begin
            for (int j = 0; j < REQ_NUM; j++) begin
                idx = (int'(rr_ptr_q) + j) % REQ_NUM;
                if (!gnt_vld && req_valid_i[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = REQ_ID_WIDTH'(idx);
                end
            end
            if (gnt_vld) req_ready_o[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        sel_msg   = req_c2v_msg_i[gnt_id*MSG_WIDTH +: MSG_WIDTH];
        conv_sign = req_v2c_sign_i[gnt_id] ^ sel_msg[MSG_WIDTH-1];
`ifdef C2V_SYMCONV_ZERO_SIGN_CLR_EN
        if (sel_msg[MSG_WIDTH-2:0] == '0) conv_sign = 1'b0;
`endif
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        count_d   = count_q;
        target_d  = target_q;
        out_vld_d = out_vld_q;
        out_msg_d = out_msg_q;
        out_id_d  = out_id_q;
        if (state_q == ST_IDLE && layer_start_i) begin
            target_d = layer_msg_cnt_i;
            count_d  = '0;
        end
        if (gnt_vld) begin
            rr_ptr_d  = (int'(gnt_id) == REQ_NUM - 1) ? '0 : gnt_id + 1'b1;
            count_d   = count_inc;
            out_vld_d = 1'b1;
            out_msg_d = {conv_sign, sel_msg[MSG_WIDTH-2:0]};
            out_id_d  = gnt_id;
        end else if (out_vld_q && out_ready_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (layer_start_i) state_d = (layer_msg_cnt_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (gnt_vld && count_inc == target_q) state_d = ST_DRAIN;
            ST_DRAIN: if (slot_free) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        layer_done_o = (state_q == ST_DONE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            count_q   <= '0;
            target_q  <= '0;
            out_vld_q <= 1'b0;
            out_msg_q <= '0;
            out_id_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            count_q   <= count_d;
            target_q  <= target_d;
            out_vld_q <= out_vld_d;
            out_msg_q <= out_msg_d;
            out_id_q  <= out_id_d;
        end
    end

    assign out_valid_o  = out_vld_q;
    assign out_msg_o    = out_msg_q;
    assign out_req_id_o = out_id_q;

endmodule
